// File: rtl/display_scan.sv
// display_scan: four-digit seven-segment scan controller with guard-banded anodes and frame-aligned value commit
module display_scan #(
    parameter int DIV   = 100000,
    parameter int GUARD = 16,
    parameter int LZB   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] value,
    output logic        busy,
    output logic [3:0]  number,
    output logic [3:0]  an,
    output logic        frame
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] GRD = CW'(GUARD);

    typedef enum logic {IDLE, PEND} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   pend_q, pend_d, disp_q, disp_d;
    logic [3:0]    number_q, number_d, an_q, an_d;
    logic          frame_q, frame_d;
    logic          wrap, boundary;

    // Next-state: outputs are computed from the next cnt/idx/disp so the registered
    // outputs line up with the counters in the same cycle.
    always_comb begin
        wrap     = cnt_q == LAST;
        boundary = wrap && idx_q == 2'd3;
        cnt_d    = wrap ? '0 : cnt_q + 1'b1;
        idx_d    = wrap ? idx_q + 2'd1 : idx_q;
        pend_d   = load ? value : pend_q;
        state_d  = boundary ? IDLE : (load ? PEND : state_q);
        disp_d   = (boundary && (load || state_q == PEND)) ? pend_d : disp_q;
        frame_d  = cnt_d == LAST && idx_d == 2'd3;
        number_d = (LZB != 0 && idx_d != 2'd0 && (disp_d >> {idx_d, 2'b00}) == 16'h0)
                   ? 4'hF : disp_d[{idx_d, 2'b00} +: 4];
        an_d     = (en && cnt_d >= GRD) ? ~(4'b0001 << idx_d) : 4'b1111;
    end

    // State and output registers with synchronous reset; a load during reset is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            pend_q   <= '0;
            disp_q   <= '0;
            number_q <= 4'h0;
            an_q     <= 4'b1111;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            disp_q   <= disp_d;
            number_q <= number_d;
            an_q     <= an_d;
            frame_q  <= frame_d;
        end
    end

    assign busy   = state_q == PEND;
    assign number = number_q;
    assign an     = an_q;
    assign frame  = frame_q;
endmodule
